// File: rtl/adder_error_monitor.sv
// adder_error_monitor
//   Sink-side accuracy checker for a registered adder under test. Every operand
//   set accepted during a window has its exact sum (X+Y+Cin) carried through a
//   LATENCY-deep shadow pipeline. When that entry reaches the end of the
//   pipeline, the shadow value is compared against the adder's dut_sum.
//   Error statistics are accumulated over a programmable number of samples.
//
//   State | Meaning
//   IDLE  | waiting for start; stats hold their last values
//   RUN   | accepting samples until window_len have been taken
//   DRAIN | no new samples; waiting for in-flight compares to finish
//   DONE  | one-cycle done pulse; stats are final
//
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   start, window_len      open a window of window_len samples (IDLE only)
//   in_valid, X, Y, Cin    operands presented to the adder this cycle
//   dut_sum                registered sum from the adder
//   busy, done, err_flag   status: window active, final pulse, per-sample error
//   sample_cnt, err_cnt    samples compared, samples in error (saturating)
//   max_err, sum_abs_err   worst |error|, accumulated |error| (saturating)
module adder_error_monitor #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16,
    parameter int ACC_W   = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] window_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic [WIDTH:0]   dut_sum,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_err,
    output logic [ACC_W-1:0] sum_abs_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LATENCY-1:0] LAST_STAGE = LATENCY'(1) << (LATENCY - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] accepted;
    logic [LATENCY-1:0] pipe_vld;
    logic [WIDTH:0]   pipe_data [LATENCY];

    logic             accept;
    logic             last_accept;
    logic             compare;
    logic             tail_empty;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   ref_sum;
    logic [WIDTH:0]   abs_err;
    logic [ACC_W:0]   acc_sum;

    assign exact       = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
    assign accept      = (state == RUN) && in_valid;
    assign last_accept = accept && (({1'b0, accepted} + 1'b1) == {1'b0, win_len});
    assign compare     = pipe_vld[LATENCY-1];
    assign ref_sum     = pipe_data[LATENCY-1];
    assign abs_err     = (ref_sum >= dut_sum) ? (ref_sum - dut_sum) : (dut_sum - ref_sum);
    assign acc_sum     = {1'b0, sum_abs_err} + (ACC_W + 1)'(abs_err);
    // The last stage may still be comparing this edge; leaving DRAIN now puts
    // DONE right after the final stats update.
    assign tail_empty  = (pipe_vld & ~LAST_STAGE) == '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (window_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (tail_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_vld[0]  <= accept;
            pipe_data[0] <= exact;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_len     <= '0;
            accepted    <= '0;
            err_flag    <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            max_err     <= '0;
            sum_abs_err <= '0;
        end else if ((state == IDLE) && start) begin
            win_len     <= window_len;
            accepted    <= '0;
            err_flag    <= 1'b0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            max_err     <= '0;
            sum_abs_err <= '0;
        end else begin
            err_flag <= compare && (abs_err != '0);
            if (accept) begin
                accepted <= accepted + 1'b1;
            end
            if (compare) begin
                if (sample_cnt != '1) begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
                if ((abs_err != '0) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (abs_err > max_err) begin
                    max_err <= abs_err;
                end
                sum_abs_err <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor. Three instances share the stimulus:
//   a: LATENCY=1, fed by a registered exact adder with injectable error
//   b: ACC_W=10, dut_sum tied to 0 (saturation of sum_abs_err)
//   c: LATENCY=3, fed by a three-stage exact adder
module tb_adder_error_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] window_len;
    logic        in_valid;
    logic [7:0]  X, Y;
    logic        Cin;
    logic [8:0]  inj;
    logic [8:0]  dut_sum_a, dut_sum_b, dut_sum_c, d1, d2;

    logic        busy_a, done_a, err_flag_a;
    logic [15:0] sample_cnt_a, err_cnt_a;
    logic [8:0]  max_err_a;
    logic [23:0] sum_abs_err_a;

    logic        busy_b, done_b, err_flag_b;
    logic [15:0] sample_cnt_b, err_cnt_b;
    logic [8:0]  max_err_b;
    logic [9:0]  sum_abs_err_b;

    logic        busy_c, done_c, err_flag_c;
    logic [15:0] sample_cnt_c, err_cnt_c;
    logic [8:0]  max_err_c;
    logic [23:0] sum_abs_err_c;

    logic [7:0]  vx [8];
    logic [7:0]  vy [8];
    logic        vc [8];
    logic [8:0]  vinj [8];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done_a = 0;
    int n_err_a  = 0;
    int n_done_c = 0;
    int snap_d, snap_e, snap_c;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        dut_sum_a <= {1'b0, X} + {1'b0, Y} + {8'b0, Cin} - inj;
        d1        <= {1'b0, X} + {1'b0, Y} + {8'b0, Cin};
        d2        <= d1;
        dut_sum_c <= d2;
    end
    assign dut_sum_b = 9'd0;

    always @(negedge clock) begin
        if (done_a) n_done_a++;
        if (err_flag_a) n_err_a++;
        if (done_c) n_done_c++;
    end

    adder_error_monitor #(.WIDTH(8), .LATENCY(1), .CNT_W(16), .ACC_W(24)) u_mon_a (
        .clock(clock), .reset(reset), .start(start), .window_len(window_len),
        .in_valid(in_valid), .X(X), .Y(Y), .Cin(Cin), .dut_sum(dut_sum_a),
        .busy(busy_a), .done(done_a), .err_flag(err_flag_a),
        .sample_cnt(sample_cnt_a), .err_cnt(err_cnt_a), .max_err(max_err_a),
        .sum_abs_err(sum_abs_err_a)
    );

    adder_error_monitor #(.WIDTH(8), .LATENCY(1), .CNT_W(16), .ACC_W(10)) u_mon_b (
        .clock(clock), .reset(reset), .start(start), .window_len(window_len),
        .in_valid(in_valid), .X(X), .Y(Y), .Cin(Cin), .dut_sum(dut_sum_b),
        .busy(busy_b), .done(done_b), .err_flag(err_flag_b),
        .sample_cnt(sample_cnt_b), .err_cnt(err_cnt_b), .max_err(max_err_b),
        .sum_abs_err(sum_abs_err_b)
    );

    adder_error_monitor #(.WIDTH(8), .LATENCY(3), .CNT_W(16), .ACC_W(24)) u_mon_c (
        .clock(clock), .reset(reset), .start(start), .window_len(window_len),
        .in_valid(in_valid), .X(X), .Y(Y), .Cin(Cin), .dut_sum(dut_sum_c),
        .busy(busy_c), .done(done_c), .err_flag(err_flag_c),
        .sample_cnt(sample_cnt_c), .err_cnt(err_cnt_c), .max_err(max_err_c),
        .sum_abs_err(sum_abs_err_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic c, input logic [8:0] e);
        vx[i]   = x;
        vy[i]   = y;
        vc[i]   = c;
        vinj[i] = e;
    endtask

    task automatic open_window(input int w);
        @(negedge clock);
        start      = 1'b1;
        window_len = 16'(w);
        @(negedge clock);
        start      = 1'b0;
    endtask

    // One sample per clock, back to back; returns at the negedge after the last accept.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            X        = vx[i];
            Y        = vy[i];
            Cin      = vc[i];
            inj      = vinj[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        inj      = 9'd0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        window_len = 16'd0;
        in_valid   = 1'b0;
        X          = 8'd0;
        Y          = 8'd0;
        Cin        = 1'b0;
        inj        = 9'd0;
        repeat (2) @(negedge clock);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_samples", 32'(sample_cnt_a), 32'd0);
        check_eq("rst_sum", 32'(sum_abs_err_a), 32'd0);
        reset = 1'b0;

        // 1: exact adder, four samples, done timing
        snap_d = n_done_a;
        set_vec(0, 8'd100, 8'd27, 1'b1, 9'd0);
        set_vec(1, 8'd255, 8'd255, 1'b1, 9'd0);
        set_vec(2, 8'd0, 8'd0, 1'b0, 9'd0);
        set_vec(3, 8'd128, 8'd128, 1'b0, 9'd0);
        open_window(4);
        check_eq("t1_busy", 32'(busy_a), 32'd1);
        send(4);
        check_eq("t1_done_early", 32'(done_a), 32'd0);
        @(negedge clock);
        check_eq("t1_done", 32'(done_a), 32'd1);
        check_eq("t1_samples", 32'(sample_cnt_a), 32'd4);
        check_eq("t1_errs", 32'(err_cnt_a), 32'd0);
        check_eq("t1_max", 32'(max_err_a), 32'd0);
        @(negedge clock);
        check_eq("t1_done_off", 32'(done_a), 32'd0);
        check_eq("t1_busy_off", 32'(busy_a), 32'd0);
        repeat (4) @(negedge clock);
        check_eq("t1_done_count", 32'(n_done_a - snap_d), 32'd1);

        // 2: one sample off by 3
        snap_d = n_done_a;
        snap_e = n_err_a;
        set_vec(0, 8'd200, 8'd100, 1'b0, 9'd3);
        set_vec(1, 8'd10, 8'd20, 1'b1, 9'd0);
        open_window(2);
        send(2);
        repeat (6) @(negedge clock);
        check_eq("t2_samples", 32'(sample_cnt_a), 32'd2);
        check_eq("t2_errs", 32'(err_cnt_a), 32'd1);
        check_eq("t2_max", 32'(max_err_a), 32'd3);
        check_eq("t2_sum", 32'(sum_abs_err_a), 32'd3);
        check_eq("t2_flag_pulses", 32'(n_err_a - snap_e), 32'd1);
        check_eq("t2_done_count", 32'(n_done_a - snap_d), 32'd1);

        // 3: alternate in_valid; extra samples (with injected error) must be ignored
        snap_d = n_done_a;
        snap_c = n_done_c;
        open_window(3);
        for (int i = 0; i < 8; i++) begin
            in_valid = ~i[0];
            X        = 8'(i * 9);
            Y        = 8'(i * 5);
            Cin      = i[1];
            inj      = (i >= 6) ? 9'd5 : 9'd0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        inj      = 9'd0;
        repeat (6) @(negedge clock);
        check_eq("t3_samples_a", 32'(sample_cnt_a), 32'd3);
        check_eq("t3_errs_a", 32'(err_cnt_a), 32'd0);
        check_eq("t3_samples_c", 32'(sample_cnt_c), 32'd3);
        check_eq("t3_errs_c", 32'(err_cnt_c), 32'd0);
        check_eq("t3_done_a", 32'(n_done_a - snap_d), 32'd1);
        check_eq("t3_done_c", 32'(n_done_c - snap_c), 32'd1);

        // 4: accumulator saturation on the ACC_W=10 instance
        for (int i = 0; i < 4; i++) set_vec(i, 8'd255, 8'd255, 1'b1, 9'd0);
        open_window(4);
        send(4);
        repeat (6) @(negedge clock);
        check_eq("t4_sum_sat", 32'(sum_abs_err_b), 32'd1023);
        check_eq("t4_max", 32'(max_err_b), 32'd511);
        check_eq("t4_errs", 32'(err_cnt_b), 32'd4);
        check_eq("t4_samples", 32'(sample_cnt_b), 32'd4);
        check_eq("t4_sum_exact", 32'(sum_abs_err_a), 32'd0);

        // 5: reset mid-window, then a normal one-sample window
        snap_d = n_done_a;
        set_vec(0, 8'd1, 8'd2, 1'b0, 9'd1);
        set_vec(1, 8'd3, 8'd4, 1'b0, 9'd1);
        open_window(10);
        send(2);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_busy", 32'(busy_a), 32'd0);
        check_eq("t5_rst_samples", 32'(sample_cnt_a), 32'd0);
        check_eq("t5_rst_errs", 32'(err_cnt_a), 32'd0);
        check_eq("t5_rst_max", 32'(max_err_a), 32'd0);
        check_eq("t5_rst_sum", 32'(sum_abs_err_a), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check_eq("t5_no_done", 32'(n_done_a - snap_d), 32'd0);
        check_eq("t5_idle", 32'(busy_a), 32'd0);
        set_vec(0, 8'd50, 8'd60, 1'b0, 9'd2);
        open_window(1);
        send(1);
        repeat (4) @(negedge clock);
        check_eq("t5_done", 32'(n_done_a - snap_d), 32'd1);
        check_eq("t5_samples", 32'(sample_cnt_a), 32'd1);
        check_eq("t5_errs", 32'(err_cnt_a), 32'd1);
        check_eq("t5_max", 32'(max_err_a), 32'd2);
        check_eq("t5_sum", 32'(sum_abs_err_a), 32'd2);

        // 6: LATENCY=3 instance, then an empty window
        snap_c = n_done_c;
        set_vec(0, 8'd17, 8'd34, 1'b1, 9'd0);
        set_vec(1, 8'd250, 8'd3, 1'b0, 9'd0);
        open_window(2);
        send(2);
        repeat (8) @(negedge clock);
        check_eq("t6_samples_c", 32'(sample_cnt_c), 32'd2);
        check_eq("t6_errs_c", 32'(err_cnt_c), 32'd0);
        check_eq("t6_max_c", 32'(max_err_c), 32'd0);
        check_eq("t6_done_c", 32'(n_done_c - snap_c), 32'd1);
        open_window(0);
        check_eq("t6_w0_done", 32'(done_a), 32'd1);
        check_eq("t6_w0_busy", 32'(busy_a), 32'd0);
        check_eq("t6_w0_samples", 32'(sample_cnt_a), 32'd0);
        check_eq("t6_w0_errs", 32'(err_cnt_a), 32'd0);
        check_eq("t6_w0_max", 32'(max_err_a), 32'd0);
        check_eq("t6_w0_sum", 32'(sum_abs_err_a), 32'd0);
        @(negedge clock);
        check_eq("t6_w0_done_off", 32'(done_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
